mole_scheduler: RTL and testbench

- Central game controller for the 10-hole whack-a-mole board.
- Decides which single hole is raised, times each pop-up window, and detects hits from the player switches.
- Keeps the score and miss count, and ends the game after too many misses.
- Drives one-hot hole enables to the per-hole display/mouse logic and exports score and status to the top level.

---
 rtl/mole_scheduler.sv | 119 +++++++++++
 tb/tb_mole_scheduler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mole_scheduler.sv
// mole_scheduler: whack-a-mole game controller (hole choice, pop-up timing, hit/miss scoring).
// Optional MOLE_WRONG_HIT_PENALTY_EN: a toggle on a non-raised hole during UP counts as a miss.
module mole_scheduler #(
    parameter int TICK_DIV = 25000000,
    parameter int UP_TICKS = 4,
    parameter int GAP_TICKS = 1,
    parameter int MAX_MISS = 5,
    parameter logic [30:0] LFSR_SEED = 31'h0000_0421
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] sw,
    output logic [9:0] hole_en,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic [7:0] score,
    output logic [3:0] misses,
    output logic       game_over,
    output logic [3:0] up_len
);
    typedef enum logic [2:0] {IDLE, GAP, UP, HIT, MISS, OVER} state_t;
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    state_t state;
    logic [CW-1:0] cnt;
    logic [3:0] tcnt, prev_idx, raw, base, idx;
    logic [9:0] s1, s2, s3, toggle;
    logic [30:0] lfsr;
    logic [7:0] score_inc;
    logic tick, gap_done, up_done, hit, wrong;
    always_comb begin
        tick = cnt == CW'(TICK_DIV - 1);
        toggle = s2 ^ s3;
        raw = lfsr[3:0];
        base = raw < 4'd10 ? raw : raw - 4'd10;
        // never raise the same hole twice in a row
        idx = base == prev_idx ? (base == 4'd9 ? 4'd0 : base + 4'd1) : base;
        gap_done = tick && ({1'b0, tcnt} + 5'd1 == 5'(GAP_TICKS));
        up_done = tick && ({1'b0, tcnt} + 5'd1 == {1'b0, up_len});
        hit = |(toggle & hole_en);
        score_inc = score == 8'hff ? 8'hff : score + 8'd1;
    end
`ifdef MOLE_WRONG_HIT_PENALTY_EN
    assign wrong = |(toggle & ~hole_en);
`else
    assign wrong = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hole_en <= '0;
            hit_pulse <= 1'b0;
            miss_pulse <= 1'b0;
            score <= '0;
            misses <= '0;
            game_over <= 1'b0;
            up_len <= 4'(UP_TICKS);
            lfsr <= LFSR_SEED;
            cnt <= '0;
            tcnt <= '0;
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            prev_idx <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
            s3 <= s2;
            if (state != IDLE) lfsr <= {lfsr[29:0], lfsr[30] ^ lfsr[27]};
            cnt <= tick ? '0 : cnt + 1'b1;
            hit_pulse <= 1'b0;
            miss_pulse <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= GAP;
                    cnt <= '0;
                    tcnt <= '0;
                end
                GAP: if (gap_done) begin
                    state <= UP;
                    tcnt <= '0;
                    hole_en <= 10'd1 << idx;
                    prev_idx <= idx;
                end else if (tick) tcnt <= tcnt + 4'd1;
                UP: if (hit) begin
                    state <= HIT;
                    hole_en <= '0;
                    hit_pulse <= 1'b1;
                    score <= score_inc;
                    if (score_inc[2:0] == 3'd0 && up_len > 4'd1) up_len <= up_len - 4'd1;
                end else if (up_done || wrong) begin
                    state <= MISS;
                    hole_en <= '0;
                    miss_pulse <= 1'b1;
                    misses <= misses + 4'd1;
                end else if (tick) tcnt <= tcnt + 4'd1;
                HIT: begin
                    state <= GAP;
                    tcnt <= '0;
                end
                MISS: begin
                    tcnt <= '0;
                    state <= misses == 4'(MAX_MISS) ? OVER : GAP;
                    game_over <= misses == 4'(MAX_MISS);
                end
                OVER: if (start) begin
                    state <= GAP;
                    cnt <= '0;
                    tcnt <= '0;
                    score <= '0;
                    misses <= '0;
                    game_over <= 1'b0;
                    up_len <= 4'(UP_TICKS);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: directed checks of the mole scheduler with a small tick divider.
module tb_mole_scheduler;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [9:0] sw = '0;
    logic [9:0] hole_en;
    logic hit_pulse, miss_pulse, game_over;
    logic [7:0] score;
    logic [3:0] misses, up_len;
    int checks = 0, errors = 0, exp_score = 0, idx = 0, prev = 0, n = 0;
    mole_scheduler #(.TICK_DIV(4), .UP_TICKS(3), .GAP_TICKS(1), .MAX_MISS(2), .LFSR_SEED(31'h421)) dut (
        .clk(clk), .rst(rst), .start(start), .sw(sw), .hole_en(hole_en), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .score(score), .misses(misses), .game_over(game_over), .up_len(up_len)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_hole(output int h);
        int k = 0;
        while (hole_en == 10'd0 && k < 60) begin
            step();
            k++;
        end
        chk("hole_timeout", 32'(k < 60), 1);
        chk("hole_onehot", $countones(hole_en), 1);
        h = 0;
        for (int i = 0; i < 10; i++) if (hole_en[i]) h = i;
    endtask
    task automatic do_hit(input int h);
        int k = 0;
        sw[h] = ~sw[h];
        while (!hit_pulse && k < 8) begin
            step();
            k++;
        end
        chk("hit_seen", 32'(hit_pulse), 1);
        exp_score = exp_score == 255 ? 255 : exp_score + 1;
        chk("hit_score", 32'(score), 32'(exp_score));
        chk("hit_hole_off", 32'(hole_en), 0);
    endtask
    initial begin
        rst = 1'b1;
        #12;
        chk("rst_hole", 32'(hole_en), 0);
        chk("rst_pulses", {30'd0, hit_pulse, miss_pulse}, 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_misses", 32'(misses), 0);
        chk("rst_over", 32'(game_over), 0);
        chk("rst_uplen", 32'(up_len), 3);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n += int'(hole_en != 0) + int'(hit_pulse) + int'(miss_pulse);
        end
        chk("idle_quiet", 32'(n), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gap_down", 32'(hole_en), 0);
        end
        step();
        chk("up_onehot", $countones(hole_en), 1);
        for (int i = 0; i < 11; i++) begin
            step();
            chk("up_no_miss", 32'(miss_pulse), 0);
        end
        step();
        chk("miss_pulse", 32'(miss_pulse), 1);
        chk("miss_hole_off", 32'(hole_en), 0);
        chk("miss_count", 32'(misses), 1);
        wait_hole(idx);
        do_hit(idx);
        prev = idx;
        wait_hole(idx);
        chk("new_hole", 32'(idx != prev), 1);
        // flip so the synchronised toggle lands on the window-expiry edge
        repeat (9) step();
        sw[idx] = ~sw[idx];
        repeat (2) step();
        chk("sim_early", {30'd0, hit_pulse, miss_pulse}, 0);
        step();
        chk("sim_hit", 32'(hit_pulse), 1);
        chk("sim_no_miss", 32'(miss_pulse), 0);
        chk("sim_score", 32'(score), 2);
        chk("sim_misses", 32'(misses), 1);
        exp_score = 2;
        for (int h = 3; h <= 256; h++) begin
            wait_hole(idx);
            do_hit(idx);
            if (h == 8) chk("uplen_8", 32'(up_len), 2);
            if (h == 24) chk("uplen_24", 32'(up_len), 1);
            if (h == 40) chk("uplen_floor", 32'(up_len), 1);
        end
        chk("score_sat", 32'(score), 255);
        chk("misses_kept", 32'(misses), 1);
        wait_hole(idx);
        prev = idx;
        sw[(idx + 1) % 10] = ~sw[(idx + 1) % 10];
        repeat (3) step();
`ifdef MOLE_WRONG_HIT_PENALTY_EN
        chk("wrong_miss", 32'(miss_pulse), 1);
        chk("wrong_misses", 32'(misses), 2);
`else
        chk("wrong_ignored_hole", 32'(hole_en), 32'(10'd1 << prev));
        chk("wrong_ignored_pulse", {30'd0, hit_pulse, miss_pulse}, 0);
`endif
        n = 0;
        while (!game_over && n < 6) begin
            step();
            n++;
        end
        chk("over_flag", 32'(game_over), 1);
        chk("over_hole", 32'(hole_en), 0);
        chk("over_score", 32'(score), 255);
        chk("over_misses", 32'(misses), 2);
        start = 1'b1;
        step();
        chk("restart_over", 32'(game_over), 0);
        chk("restart_score", 32'(score), 0);
        chk("restart_misses", 32'(misses), 0);
        chk("restart_uplen", 32'(up_len), 3);
        wait_hole(idx);
        start = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        chk("arst_hole", 32'(hole_en), 0);
        chk("arst_pulses", {30'd0, hit_pulse, miss_pulse}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) step();
        chk("arst_idle", 32'(hole_en), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
